// File: rtl/mpc_memctl_rsp_pkg.sv
// Shared MPC types for the memory-controller responder: geometry, request op,
// queue entry layout and line-id helpers.
package mpc_types;

    typedef struct packed {
        int unsigned setWidth;
        int unsigned wayIndexWidth;
        int unsigned nlineWidth;
        int unsigned offsetWidth;
    } mpc_cfg_t;

    localparam mpc_cfg_t MPC_CFG = '{
        setWidth:      32'd3,
        wayIndexWidth: 32'd2,
        nlineWidth:    32'd5,
        offsetWidth:   32'd5
    };

    localparam int SET_W    = int'(MPC_CFG.setWidth);
    localparam int WAY_W    = int'(MPC_CFG.wayIndexWidth);
    localparam int NLINE_W  = int'(MPC_CFG.nlineWidth);
    localparam int OFFSET_W = int'(MPC_CFG.offsetWidth);
    localparam int ADDR_W   = 32;
    localparam int BEAT_W   = 128;
    localparam int BEATS    = 2;
    localparam int QDEPTH   = 4;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int LINE_W   = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        MC_OP_REFILL = 3'd1
    } mpc_memctl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BEAT = 2'd2,
        ST_DONE = 2'd3
    } memctl_state_e;

    typedef struct packed {
        logic [NLINE_W-1:0] id;
        logic [LINE_W-1:0]  line;
    } memctl_req_t;

    // Line id is {way, set}
    function automatic logic [SET_W-1:0] id_set(input logic [NLINE_W-1:0] id);
        return id[SET_W-1:0];
    endfunction

    function automatic logic [WAY_W-1:0] id_way(input logic [NLINE_W-1:0] id);
        return id[NLINE_W-1:SET_W];
    endfunction

endpackage

// File: rtl/mpc_memctl_rsp_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB separates
// full from empty. Push is ignored when full, pop is ignored when empty.
module mpc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mpc_memctl_rsp.sv
// MPC memory-controller responder: queues refill requests, issues one line read
// at a time, streams beats into the data array and pulses refill-done.
module mpc_memctl_rsp
    import mpc_types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                u_memctl_valid,
    output logic                u_memctl_ready,
    input  logic [2:0]          u_memctl_op,
    input  logic [NLINE_W-1:0]  u_memctl_id,
    input  logic [ADDR_W-1:0]   u_memctl_addr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [BEAT_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_last,
    output logic                dat_wr_valid,
    output logic [SET_W-1:0]    dat_wr_set,
    output logic [WAY_W-1:0]    dat_wr_way,
    output logic [CNT_W-1:0]    dat_wr_word,
    output logic [BEAT_W-1:0]   dat_wr_data,
    output logic                d_refill_valid,
    output logic [SET_W-1:0]    d_refill_set,
    output logic [WAY_W-1:0]    d_refill_way,
    output logic                err_illegal_op,
    output logic                err_beat
);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BEATS - 1);

    memctl_req_t        push_req_s;
    memctl_req_t        head_s;
    logic               q_full_s;
    logic               q_empty_s;
    logic               q_push_s;
    logic               q_pop_s;
    logic               legal_op_s;
    logic               in_hs_s;
    logic               beat_hs_s;
    logic               last_word_s;
    logic               unused_s;

    memctl_state_e      state_r;
    logic [SET_W-1:0]   set_r;
    logic [WAY_W-1:0]   way_r;
    logic [LINE_W-1:0]  line_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               mem_req_valid_r;
    logic               refill_r;
    logic               err_op_r;
    logic               err_beat_r;

    // in_ready_r keeps the request port closed while reset is applied
    assign legal_op_s     = (u_memctl_op == MC_OP_REFILL);
    assign u_memctl_ready = in_ready_r && !q_full_s;
    assign in_hs_s        = u_memctl_valid && u_memctl_ready;
    assign q_push_s       = in_hs_s && legal_op_s;
    assign q_pop_s        = (state_r == ST_IDLE) && !q_empty_s;
    assign push_req_s     = '{id: u_memctl_id, line: u_memctl_addr[ADDR_W-1:OFFSET_W]};
    assign unused_s       = ^u_memctl_addr[OFFSET_W-1:0];

    mpc_sync_fifo #(
        .WIDTH ($bits(memctl_req_t)),
        .DEPTH (QDEPTH)
    ) u_req_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push_s),
        .push_data (push_req_s),
        .pop       (q_pop_s),
        .pop_data  (head_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    assign mem_req_valid  = mem_req_valid_r;
    assign mem_req_addr   = {line_r, {OFFSET_W{1'b0}}};
    assign mem_rsp_ready  = (state_r == ST_BEAT);
    assign beat_hs_s      = mem_rsp_valid && mem_rsp_ready;
    assign last_word_s    = (cnt_r == LAST_WORD);

    assign dat_wr_valid   = beat_hs_s;
    assign dat_wr_set     = set_r;
    assign dat_wr_way     = way_r;
    assign dat_wr_word    = cnt_r;
    assign dat_wr_data    = beat_hs_s ? mem_rsp_data : {BEAT_W{1'b0}};

    assign d_refill_valid = refill_r;
    assign d_refill_set   = set_r;
    assign d_refill_way   = way_r;
    assign err_illegal_op = err_op_r;
    assign err_beat       = err_beat_r;

    // Refill sequencer: one outstanding line read, beat counter decides line end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            set_r           <= {SET_W{1'b0}};
            way_r           <= {WAY_W{1'b0}};
            line_r          <= {LINE_W{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            in_ready_r      <= 1'b0;
            mem_req_valid_r <= 1'b0;
            refill_r        <= 1'b0;
            err_op_r        <= 1'b0;
            err_beat_r      <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
            if (in_hs_s && !legal_op_s) begin
                err_op_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!q_empty_s) begin
                        set_r   <= id_set(head_s.id);
                        way_r   <= id_way(head_s.id);
                        line_r  <= head_s.line;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!mem_req_valid_r) begin
                        mem_req_valid_r <= 1'b1;
                    end else if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        cnt_r           <= {CNT_W{1'b0}};
                        state_r         <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (beat_hs_s) begin
                        if (mem_rsp_last != last_word_s) begin
                            err_beat_r <= 1'b1;
                        end
                        if (last_word_s) begin
                            cnt_r    <= {CNT_W{1'b0}};
                            refill_r <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    refill_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    mem_req_valid_r <= 1'b0;
                    refill_r        <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_memctl_rsp.sv
// Scoreboard bench for mpc_memctl_rsp: directed requests push expected memory
// reads, array writes and refill pulses; a negedge monitor pops and compares.
module tb_mpc_memctl_rsp;
    import mpc_types::*;

    typedef struct {
        logic [2:0]   set;
        logic [1:0]   way;
        logic         word;
        logic [127:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         u_memctl_valid = 1'b0;
    logic         u_memctl_ready;
    logic [2:0]   u_memctl_op = 3'd0;
    logic [4:0]   u_memctl_id = 5'd0;
    logic [31:0]  u_memctl_addr = 32'd0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic         mem_rsp_ready;
    logic [127:0] mem_rsp_data = 128'd0;
    logic         mem_rsp_last = 1'b0;
    logic         dat_wr_valid;
    logic [2:0]   dat_wr_set;
    logic [1:0]   dat_wr_way;
    logic [0:0]   dat_wr_word;
    logic [127:0] dat_wr_data;
    logic         d_refill_valid;
    logic [2:0]   d_refill_set;
    logic [1:0]   d_refill_way;
    logic         err_illegal_op;
    logic         err_beat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_req[$];
    wr_t         exp_wr[$];
    logic [4:0]  exp_ref[$];

    always #5 clk = ~clk;

    mpc_memctl_rsp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .u_memctl_valid (u_memctl_valid),
        .u_memctl_ready (u_memctl_ready),
        .u_memctl_op    (u_memctl_op),
        .u_memctl_id    (u_memctl_id),
        .u_memctl_addr  (u_memctl_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_last   (mem_rsp_last),
        .dat_wr_valid   (dat_wr_valid),
        .dat_wr_set     (dat_wr_set),
        .dat_wr_way     (dat_wr_way),
        .dat_wr_word    (dat_wr_word),
        .dat_wr_data    (dat_wr_data),
        .d_refill_valid (d_refill_valid),
        .d_refill_set   (d_refill_set),
        .d_refill_way   (d_refill_way),
        .err_illegal_op (err_illegal_op),
        .err_beat       (err_beat)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got unexpected/missing event, required none", name);
    endtask

    function automatic logic [127:0] beat_data(input logic [31:0] line_addr, input int b);
        return {4{line_addr ^ 32'(b)}};
    endfunction

    task automatic expect_line(input logic [4:0] id, input logic [31:0] a);
        logic [31:0] line;
        line = a & 32'hffff_ffe0;
        exp_req.push_back(line);
        for (int b = 0; b < 2; b++) begin
            exp_wr.push_back('{id[2:0], id[4:3], 1'(b), beat_data(line, b)});
        end
        exp_ref.push_back(id);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic send_req(input logic [2:0] op, input logic [4:0] id, input logic [31:0] a);
        int t = 0;
        u_memctl_valid = 1'b1; u_memctl_op = op; u_memctl_id = id; u_memctl_addr = a;
        while (!u_memctl_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!u_memctl_ready) fail_now("req_accept_timeout");
        @(posedge clk); #1;
        u_memctl_valid = 1'b0;
    endtask

    task automatic serve_line(input logic [31:0] line, input int req_wait, input int gap,
                              input bit early, input int nbeats);
        int t = 0;
        while (!mem_req_valid && t < 200) begin @(posedge clk); #1; t++; end
        if (!mem_req_valid) begin
            fail_now("mem_req_timeout");
            return;
        end
        idle(req_wait);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            idle(gap);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = beat_data(line, b);
            mem_rsp_last  = early ? (b == 0) : (b == BEATS - 1);
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_last  = 1'b0;
        end
    endtask

    initial begin
        logic [4:0]  ids[6];
        logic [31:0] addrs[6];
        wr_t         e;
        ids   = '{5'd3, 5'd10, 5'd17, 5'd24, 5'd31, 5'd6};
        addrs = '{32'h1000_0004, 32'h2000_0040, 32'h3000_009f,
                  32'h4000_00e1, 32'h5000_0100, 32'h6000_013c};

        fork
            // Monitor: every presented output must match the queue head
            forever begin
                @(negedge clk);
                if (mem_req_valid) begin
                    if (exp_req.size() == 0) fail_now("mem_req_unexpected");
                    else begin
                        chk("mem_req_addr", 128'(mem_req_addr), 128'(exp_req[0]));
                        if (mem_req_ready) void'(exp_req.pop_front());
                    end
                end
                if (dat_wr_valid) begin
                    if (exp_wr.size() == 0) fail_now("dat_wr_unexpected");
                    else begin
                        e = exp_wr.pop_front();
                        chk("dat_wr_loc", 128'({dat_wr_set, dat_wr_way, dat_wr_word}),
                            128'({e.set, e.way, e.word}));
                        chk("dat_wr_data", dat_wr_data, e.data);
                    end
                end
                if (d_refill_valid) begin
                    if (exp_ref.size() == 0) fail_now("refill_unexpected");
                    else chk("refill_setway", 128'({d_refill_way, d_refill_set}),
                             128'(exp_ref.pop_front()));
                end
            end
            begin
                #100000;
                $display("FAIL watchdog: got no finish, required finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        idle(3);
        chk("rst_u_ready", 128'(u_memctl_ready), 128'(0));
        chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_req_addr", 128'(mem_req_addr), 128'(0));
        chk("rst_rsp_ready", 128'(mem_rsp_ready), 128'(0));
        chk("rst_refill", 128'({d_refill_valid, dat_wr_valid}), 128'(0));
        chk("rst_errs", 128'({err_illegal_op, err_beat}), 128'(0));
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_ready", 128'(u_memctl_ready), 128'(1));

        // Single refill with latency checks
        exp_req.push_back(32'hff00_0020);
        exp_wr.push_back('{3'd1, 2'd0, 1'b0, {4{32'hff00_0020}}});
        exp_wr.push_back('{3'd1, 2'd0, 1'b1, {4{32'hff00_0021}}});
        exp_ref.push_back(5'd1);
        send_req(3'd1, 5'd1, 32'hff00_0024);
        chk("lat_edge_n", 128'(mem_req_valid), 128'(0));
        idle(1);
        chk("lat_edge_n1", 128'(mem_req_valid), 128'(0));
        idle(1);
        chk("lat_edge_n2", 128'(mem_req_valid), 128'(1));
        serve_line(32'hff00_0020, 0, 0, 1'b0, 2);
        chk("refill_lat", 128'(d_refill_valid), 128'(1));
        idle(3);

        // Queue fill with memory stalled
        for (int i = 0; i < 5; i++) begin
            expect_line(ids[i], addrs[i]);
            send_req(3'd1, ids[i], addrs[i]);
        end
        chk("queue_full_ready", 128'(u_memctl_ready), 128'(0));
        expect_line(ids[5], addrs[5]);
        fork
            send_req(3'd1, ids[5], addrs[5]);
        join_none
        idle(3);
        chk("queue_full_hold", 128'({u_memctl_valid, u_memctl_ready}), 128'(2'b10));
        for (int i = 0; i < 6; i++) begin
            serve_line(addrs[i] & 32'hffff_ffe0, 0, 0, 1'b0, 2);
        end
        idle(3);

        // Illegal op
        chk("err_op_before", 128'(err_illegal_op), 128'(0));
        send_req(3'd2, 5'd9, 32'h7000_0000);
        idle(6);
        chk("err_op_set", 128'(err_illegal_op), 128'(1));
        chk("err_op_no_req", 128'(mem_req_valid), 128'(0));

        // Early last
        expect_line(5'd12, 32'h8000_0044);
        send_req(3'd1, 5'd12, 32'h8000_0044);
        serve_line(32'h8000_0040, 0, 0, 1'b1, 2);
        idle(3);
        chk("err_beat_set", 128'(err_beat), 128'(1));

        // Reset mid-BEAT: only the request and beat 0 are expected
        exp_req.push_back(32'ha000_0080);
        exp_wr.push_back('{3'd4, 2'd1, 1'b0, {4{32'ha000_0080}}});
        send_req(3'd1, 5'd12, 32'ha000_0084);
        serve_line(32'ha000_0080, 0, 0, 1'b0, 1);
        rst_n = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beat_data(32'ha000_0080, 1);
        mem_rsp_last  = 1'b1;
        #1;
        chk("midrst_rsp_ready", 128'(mem_rsp_ready), 128'(0));
        chk("midrst_outs", 128'({dat_wr_valid, d_refill_valid, mem_req_valid, u_memctl_ready}), 128'(0));
        chk("midrst_errs", 128'({err_illegal_op, err_beat}), 128'(0));
        idle(2);
        rst_n = 1'b1;
        idle(3);
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;

        // Next request after reset, with memory backpressure and beat gaps
        expect_line(5'd21, 32'h9000_0060);
        send_req(3'd1, 5'd21, 32'h9000_0060);
        serve_line(32'h9000_0060, 7, 3, 1'b0, 2);
        idle(5);
        chk("final_errs", 128'({err_illegal_op, err_beat}), 128'(0));
        chk("exp_req_drained", 128'(exp_req.size()), 128'(0));
        chk("exp_wr_drained", 128'(exp_wr.size()), 128'(0));
        chk("exp_ref_drained", 128'(exp_ref.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
